// File: rtl/ecc_error_campaign_ctrl_pkg.sv
// Shared types for the ECC error-injection campaign sequencer.
package ecc_campaign_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2
  } err_kind_e;

  // Length of a campaign for a given codeword width and phase selection.
  function automatic int unsigned num_patterns(input int unsigned dw,
                                               input logic single_en,
                                               input logic double_en);
    int unsigned n;
    n = 0;
    if (single_en) n = n + dw;
    if (double_en) n = n + (dw * (dw - 1)) / 2;
    return n;
  endfunction

endpackage

// File: rtl/ecc_error_campaign_ctrl_if.sv
// Upstream/downstream word streams of the campaign sequencer, incl. error sideband.
interface ecc_error_campaign_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 39,
  parameter int unsigned POS_W      = $clog2(DATA_WIDTH)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_err_kind;
  logic [POS_W-1:0]      out_pos1;
  logic [POS_W-1:0]      out_pos2;

  // master: the environment feeding words in and consuming corrupted words
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_kind, out_pos1, out_pos2
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_kind, out_pos1, out_pos2
  );
endinterface

// File: rtl/ecc_error_campaign_ctrl_channel.sv
// Combinational channel: flips bit pos1, and also pos2 when sed_ded is set.
module channel_model #(
  parameter int unsigned DATA_WIDTH = 39,
  parameter int unsigned POS_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [POS_W-1:0]      i_pos1,
  input  logic [POS_W-1:0]      i_pos2,
  input  logic                  i_sed_ded,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DATA_WIDTH-1:0] w_mask;

  always_comb begin
    w_mask         = '0;
    w_mask[i_pos1] = 1'b1;
    if (i_sed_ded) w_mask[i_pos2] = 1'b1;
  end

  assign o_data = i_data ^ w_mask;
endmodule

// File: rtl/ecc_error_campaign_ctrl.sv
// Error-injection campaign sequencer: every single-bit flip, then every distinct bit pair,
// one pattern per accepted word; bypass outside a campaign.
module ecc_error_campaign_ctrl
  import ecc_campaign_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 39,
  parameter int unsigned POS_W      = $clog2(DATA_WIDTH),
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH * (DATA_WIDTH + 1) / 2 + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cfg_single_en,
  input  logic                      cfg_double_en,
  ecc_error_campaign_ctrl_if.slave  bus,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          pattern_cnt
);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DATA_WIDTH - 1);
  localparam logic [POS_W-1:0] PEN_POS  = POS_W'(DATA_WIDTH - 2);

  state_e                r_state;
  logic [POS_W-1:0]      r_p1;
  logic [POS_W-1:0]      r_p2;
  logic                  r_cfg_double;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  err_kind_e             r_out_kind;
  logic [POS_W-1:0]      r_out_pos1;
  logic [POS_W-1:0]      r_out_pos2;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_sed_ded;
  logic [DATA_WIDTH-1:0] w_chan_data;
  logic [DATA_WIDTH-1:0] w_out_data;
  err_kind_e             w_out_kind;
  logic [POS_W-1:0]      w_out_pos1;
  logic [POS_W-1:0]      w_out_pos2;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sed_ded  = (r_state == DOUBLE);

  channel_model #(
    .DATA_WIDTH (DATA_WIDTH),
    .POS_W      (POS_W)
  ) u_channel (
    .i_data    (bus.in_data),
    .i_pos1    (r_p1),
    .i_pos2    (r_p2),
    .i_sed_ded (w_sed_ded),
    .o_data    (w_chan_data)
  );

  // The pattern follows the pre-edge state, so abort/start cycles see the current pattern.
  always_comb begin
    w_out_data = bus.in_data;
    w_out_kind = ERR_NONE;
    w_out_pos1 = '0;
    w_out_pos2 = '0;
    case (r_state)
      SINGLE: begin
        w_out_data = w_chan_data;
        w_out_kind = ERR_SINGLE;
        w_out_pos1 = r_p1;
      end
      DOUBLE: begin
        w_out_data = w_chan_data;
        w_out_kind = ERR_DOUBLE;
        w_out_pos1 = r_p1;
        w_out_pos2 = r_p2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_p1         <= '0;
      r_p2         <= '0;
      r_cfg_double <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_kind   <= ERR_NONE;
      r_out_pos1   <= '0;
      r_out_pos2   <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_data;
        r_out_kind  <= w_out_kind;
        r_out_pos1  <= w_out_pos1;
        r_out_pos2  <= w_out_pos2;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (start && (r_state == IDLE || r_state == DONE)) begin
        r_cfg_double <= cfg_double_en;
        r_cnt        <= '0;
        r_p1         <= '0;
        r_p2         <= POS_W'(1);
        if (cfg_single_en) begin
          r_state <= SINGLE;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end else if (cfg_double_en) begin
          r_state <= DOUBLE;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end else begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (w_accept && r_state == SINGLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_p1 == LAST_POS) begin
          r_p1 <= '0;
          r_p2 <= POS_W'(1);
          if (r_cfg_double) begin
            r_state <= DOUBLE;
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_p1 <= r_p1 + POS_W'(1);
        end
      end else if (w_accept && r_state == DOUBLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_p2 == LAST_POS) begin
          if (r_p1 == PEN_POS) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_p1 <= r_p1 + POS_W'(1);
            r_p2 <= r_p1 + POS_W'(2);
          end
        end else begin
          r_p2 <= r_p2 + POS_W'(1);
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_err_kind = r_out_kind;
  assign bus.out_pos1     = r_out_pos1;
  assign bus.out_pos2     = r_out_pos2;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pattern_cnt      = r_cnt;
endmodule

// File: tb/tb_ecc_error_campaign_ctrl.sv
// Directed bench for ecc_error_campaign_ctrl with hand-derived expected patterns.
module tb_ecc_error_campaign_ctrl;
  localparam int unsigned DW  = 39;
  localparam int unsigned PW  = 6;
  localparam int unsigned CW  = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          cfg_s;
  logic          cfg_d;
  logic          busy;
  logic          done;
  logic [CW-1:0] pattern_cnt;

  int vectors;
  int miscompares;

  ecc_error_campaign_ctrl_if #(.DATA_WIDTH(DW), .POS_W(PW)) bus ();

  ecc_error_campaign_ctrl #(
    .DATA_WIDTH (DW),
    .POS_W      (PW),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_single_en (cfg_s),
    .cfg_double_en (cfg_d),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .pattern_cnt   (pattern_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.out_err_kind !== 2'd0 || bus.out_pos1 !== 6'd0 || bus.out_pos2 !== 6'd0) begin
      miscompares++; $display("FAIL rst_sideband: got kind %0d pos %0d/%0d want 0 0/0", bus.out_err_kind, bus.out_pos1, bus.out_pos2); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    vectors++; if (pattern_cnt !== 10'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", pattern_cnt); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_bypass();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 39'h12_3456_789A;
    step();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 39'h12_3456_789A) begin
      miscompares++; $display("FAIL bypass_data: got v=%b %h want v=1 123456789a", bus.out_valid, bus.out_data); end
    vectors++; if (bus.out_err_kind !== 2'd0 || bus.out_pos1 !== 6'd0 || bus.out_pos2 !== 6'd0) begin
      miscompares++; $display("FAIL bypass_sideband: got kind %0d pos %0d/%0d want 0 0/0", bus.out_err_kind, bus.out_pos1, bus.out_pos2); end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bypass_drain: out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_full_campaign();
    logic [DW-1:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    start = 1'b1; cfg_s = 1'b1; cfg_d = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || pattern_cnt !== 10'd0) begin
      miscompares++; $display("FAIL full_start: busy %b cnt %0d want 1 0", busy, pattern_cnt); end
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    for (int k = 0; k < 39; k++) begin
      step();
      exp = '0; exp[k] = 1'b1;
      vectors++; if (bus.out_data !== exp || bus.out_err_kind !== 2'd1 || bus.out_pos1 !== 6'(k) || bus.out_pos2 !== 6'd0) begin
        miscompares++; $display("FAIL full_single[%0d]: got %h kind %0d pos %0d/%0d want %h 1 %0d/0",
                                k, bus.out_data, bus.out_err_kind, bus.out_pos1, bus.out_pos2, exp, k); end
    end
    for (int i = 0; i < 38; i++) begin
      for (int j = i + 1; j < 39; j++) begin
        step();
        exp = '0; exp[i] = 1'b1; exp[j] = 1'b1;
        vectors++; if (bus.out_data !== exp || bus.out_err_kind !== 2'd2 || bus.out_pos1 !== 6'(i) || bus.out_pos2 !== 6'(j)) begin
          miscompares++; $display("FAIL full_double[%0d,%0d]: got %h kind %0d pos %0d/%0d want %h 2 %0d/%0d",
                                  i, j, bus.out_data, bus.out_err_kind, bus.out_pos1, bus.out_pos2, exp, i, j); end
      end
    end
    bus.in_valid = 1'b0;
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || pattern_cnt !== 10'd780) begin
      miscompares++; $display("FAIL full_done: done %b busy %b cnt %0d want 1 0 780", done, busy, pattern_cnt); end
    bus.in_valid = 1'b1;
    bus.in_data  = 39'h12_3456_789A;
    step();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_data !== 39'h12_3456_789A || bus.out_err_kind !== 2'd0) begin
      miscompares++; $display("FAIL full_post_bypass: got %h kind %0d want 123456789a 0", bus.out_data, bus.out_err_kind); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    start = 1'b1; cfg_s = 1'b1; cfg_d = 1'b0;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    repeat (10) step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      exp = '0; exp[9] = 1'b1;
      vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_pos1 !== 6'd9 || pattern_cnt !== 10'd10) begin
        miscompares++; $display("FAIL bp_hold[%0d]: rdy %b v %b data %h pos %0d cnt %0d want 0 1 %h 9 10",
                                c, bus.in_ready, bus.out_valid, bus.out_data, bus.out_pos1, pattern_cnt, exp); end
    end
    bus.out_ready = 1'b1;
    for (int k = 10; k < 39; k++) begin
      step();
      exp = '0; exp[k] = 1'b1;
      vectors++; if (bus.out_data !== exp || bus.out_pos1 !== 6'(k) || bus.out_err_kind !== 2'd1) begin
        miscompares++; $display("FAIL bp_resume[%0d]: got %h pos %0d kind %0d want %h %0d 1",
                                k, bus.out_data, bus.out_pos1, bus.out_err_kind, exp, k); end
    end
    bus.in_valid = 1'b0;
    vectors++; if (done !== 1'b1 || pattern_cnt !== 10'd39) begin
      miscompares++; $display("FAIL bp_single_only_done: done %b cnt %0d want 1 39", done, pattern_cnt); end
  endtask

  task automatic test_cfg_variants();
    logic [DW-1:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    start = 1'b1; cfg_s = 1'b0; cfg_d = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    step();
    vectors++; if (bus.out_data !== 39'h3 || bus.out_err_kind !== 2'd2 || bus.out_pos1 !== 6'd0 || bus.out_pos2 !== 6'd1) begin
      miscompares++; $display("FAIL dbl_only_first: got %h kind %0d pos %0d/%0d want 3 2 0/1",
                              bus.out_data, bus.out_err_kind, bus.out_pos1, bus.out_pos2); end
    repeat (739) step();
    vectors++; if (done !== 1'b0 || busy !== 1'b1 || pattern_cnt !== 10'd740) begin
      miscompares++; $display("FAIL dbl_only_before_last: done %b busy %b cnt %0d want 0 1 740", done, busy, pattern_cnt); end
    step();
    bus.in_valid = 1'b0;
    exp = '0; exp[37] = 1'b1; exp[38] = 1'b1;
    vectors++; if (bus.out_data !== exp || bus.out_pos1 !== 6'd37 || bus.out_pos2 !== 6'd38) begin
      miscompares++; $display("FAIL dbl_only_last: got %h pos %0d/%0d want %h 37/38", bus.out_data, bus.out_pos1, bus.out_pos2, exp); end
    vectors++; if (done !== 1'b1 || pattern_cnt !== 10'd741) begin
      miscompares++; $display("FAIL dbl_only_done: done %b cnt %0d want 1 741", done, pattern_cnt); end
    start = 1'b1; cfg_s = 1'b0; cfg_d = 1'b0;
    step();
    start = 1'b0;
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || pattern_cnt !== 10'd0) begin
      miscompares++; $display("FAIL empty_campaign: done %b busy %b cnt %0d want 1 0 0", done, busy, pattern_cnt); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    start = 1'b1; cfg_s = 1'b0; cfg_d = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    repeat (183) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp = '0; exp[5] = 1'b1; exp[9] = 1'b1;
    vectors++; if (bus.out_data !== exp || bus.out_err_kind !== 2'd2 || bus.out_pos1 !== 6'd5 || bus.out_pos2 !== 6'd9) begin
      miscompares++; $display("FAIL abort_word: got %h kind %0d pos %0d/%0d want %h 2 5/9",
                              bus.out_data, bus.out_err_kind, bus.out_pos1, bus.out_pos2, exp); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || pattern_cnt !== 10'd183) begin
      miscompares++; $display("FAIL abort_status: busy %b done %b cnt %0d want 0 0 183", busy, done, pattern_cnt); end
    bus.in_data = 39'h55_AAAA_5555;
    step();
    vectors++; if (bus.out_data !== 39'h55_AAAA_5555 || bus.out_err_kind !== 2'd0) begin
      miscompares++; $display("FAIL abort_next_bypass: got %h kind %0d want 55aaaa5555 0", bus.out_data, bus.out_err_kind); end
    bus.in_valid = 1'b0;
    start = 1'b1; abort = 1'b1; cfg_s = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0 || pattern_cnt !== 10'd183) begin
      miscompares++; $display("FAIL start_abort_same: busy %b cnt %0d want 0 183", busy, pattern_cnt); end
    start = 1'b1; cfg_s = 1'b1; cfg_d = 1'b0;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (bus.out_pos1 !== 6'd3 || pattern_cnt !== 10'd4 || busy !== 1'b1) begin
      miscompares++; $display("FAIL start_while_busy: pos %0d cnt %0d busy %b want 3 4 1", bus.out_pos1, pattern_cnt, busy); end
    step();
    vectors++; if (bus.out_pos1 !== 6'd4 || pattern_cnt !== 10'd5) begin
      miscompares++; $display("FAIL after_busy_start: pos %0d cnt %0d want 4 5", bus.out_pos1, pattern_cnt); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_campaign();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    repeat (3) step();
    bus.out_ready = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_pos1 !== 6'd0) begin
      miscompares++; $display("FAIL async_reset: v %b data %h pos %0d want 0 0 0", bus.out_valid, bus.out_data, bus.out_pos1); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || pattern_cnt !== 10'd0) begin
      miscompares++; $display("FAIL async_reset_status: busy %b done %b cnt %0d want 0 0 0", busy, done, pattern_cnt); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 39'h7F_0000_0001;
    step();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_data !== 39'h7F_0000_0001 || bus.out_err_kind !== 2'd0) begin
      miscompares++; $display("FAIL reset_then_bypass: got %h kind %0d want 7f00000001 0", bus.out_data, bus.out_err_kind); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; cfg_s = 1'b0; cfg_d = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_bypass();
    test_full_campaign();
    test_backpressure();
    test_cfg_variants();
    test_abort();
    start = 1'b1; cfg_s = 1'b1; cfg_d = 1'b1;
    step();
    start = 1'b0;
    test_reset_mid_campaign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ecc_error_campaign_ctrl.md
Name: ecc_error_campaign_ctrl

Overview:
- Sequencer for the ECC channel error-injection path.
- Accepts codewords over a valid/ready stream and runs an exhaustive error campaign on them, one pattern per word: every single-bit flip position, then every distinct double-bit pair.
- Drives a channel_model instance and emits the corrupted word plus error sideband to the decoder and scoreboard.
- Outside a campaign, words pass through unmodified.

Parameters:
DATA_WIDTH, 39, codeword width (32 data + 7 SECDED check bits)
POS_W, $clog2(DATA_WIDTH), error-position index width
CNT_W, $clog2(DATA_WIDTH*(DATA_WIDTH+1)/2+1), pattern counter width (10 at default)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins campaign when not busy
abort  in  1  pulse; ends campaign immediately
cfg_single_en  in  1  include single-error phase; sampled on accepted start
cfg_double_en  in  1  include double-error phase; sampled on accepted start
in_valid  in  1  upstream word valid
in_ready  out  1  upstream ready
in_data  in  DATA_WIDTH  clean codeword
out_valid  out  1  downstream valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  corrupted (or bypassed) codeword
out_err_kind  out  2  0=none, 1=single, 2=double (3 unused)
out_pos1  out  POS_W  first flipped bit (0 if none)
out_pos2  out  POS_W  second flipped bit (0 if none/single)
busy  out  1  campaign in progress
done  out  1  campaign completed; level until start or abort
pattern_cnt  out  CNT_W  patterns applied in current/last campaign

Behaviour:
- Reset: state IDLE; out_valid=0, out_data=0, out_err_kind=0, out_pos1=0, out_pos2=0, busy=0, done=0, pattern_cnt=0, latched cfg=0.
- Handshake:
  - Single output register; in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready; output updates on accept with latency 1 cycle.
  - out_valid clears when out_ready is high and there is no accept.
  - out_* hold stable while out_valid && !out_ready.
- FSM states:
  - IDLE, DONE: bypass; kind=0, positions 0, data unmodified.
  - SINGLE: pattern (p1); channel sed_ded=0; kind=1.
  - DOUBLE: pattern (p1,p2), p1<p2 always; channel sed_ded=1; kind=2.
- Start:
  - Accepted in IDLE or DONE only; ignored in SINGLE/DOUBLE.
  - On start: latch cfg, clear done and pattern_cnt, p1=0. Next state: SINGLE if single_en; else DOUBLE with p2=1 if double_en; else DONE.
  - A word accepted in the start cycle is bypassed. The first pattern applies to the next accept.
- Advance only on accept, in SINGLE/DOUBLE; pattern_cnt+1 per accept.
  - SINGLE: p1 increments. After p1=DATA_WIDTH-1, go to DOUBLE (p1=0, p2=1) if double_en, else DONE.
  - DOUBLE: p2 increments. At p2=DATA_WIDTH-1: p1++, p2=p1_new+1. After (DATA_WIDTH-2, DATA_WIDTH-1), go to DONE.
- Totals at default: 39 single + 741 double = 780 patterns.
- busy=1 in SINGLE/DOUBLE; done=1 in DONE.
- Abort:
  - Has priority over advance; from any state goes to IDLE, busy=0, done=0.
  - pattern_cnt holds until next start.
  - A word accepted in the abort cycle still receives the current pattern.
- Simultaneous start and abort: abort wins.
- Reset mid-campaign: immediate return to reset values; any in-flight output word is dropped.
- Position width: positions never exceed DATA_WIDTH-1. Zero-extend or truncate to the channel_model port width, which must cover DATA_WIDTH-1.

Decomposition:
- Package ecc_campaign_pkg:
  - state enum {IDLE, SINGLE, DOUBLE, DONE}.
  - err_kind enum {ERR_NONE=0, ERR_SINGLE=1, ERR_DOUBLE=2}.
  - Function num_patterns(DATA_WIDTH, single_en, double_en).
- Sub-module: instantiate existing channel_model combinationally on in_data with the current p1/p2/sed_ded. Mux its output against in_data for bypass before the output register.

Test Plan:
1. Assert rst_n=0 mid-traffic, release -> all outputs 0, in_ready=1, state IDLE.
2. IDLE, in_data=39'h12_3456_789A, out_ready=1 -> next cycle out_data=39'h12_3456_789A, kind=0, pos 0/0.
3. Start (both en), stream 780 zero words, out_ready=1:
   - word k<39 -> out_data=1<<k, kind=1, pos1=k.
   - word 39 -> 39'h3, kind=2, (0,1).
   - word 779 -> bits 37|38, kind=2, (37,38).
   - Then done=1, pattern_cnt=780, word 781 bypassed.
4. Mid-SINGLE hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, pattern_cnt unchanged. Release -> sequence resumes without skipping or duplicating a position.
5. cfg_single_en=0, cfg_double_en=1 -> first word (0,1), done after 741 words. Both 0 -> done=1 one cycle after start, pattern_cnt=0.
6. Abort in the same cycle as an accept at pattern (5,9):
   - That word carries bits 5|9; next word bypassed; busy=0, done=0.
   - pattern_cnt holds; start during busy has no effect.
